// File: rtl/aes128_enc_ctrl_pkg.sv
// AES-128 round primitives, constants and controller state type shared by the
// encryption controller and its key-schedule step.
package hea_func_pack;

    localparam int unsigned NR = 10;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        DONE
    } aes_ctrl_state_t;

    // S-box, element b is the substitution of byte value b.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Round constant for round r; zero outside 1..NR so an idle counter is harmless.
    function automatic logic [7:0] get_rcon(input logic [3:0] r);
        if (r >= 4'd1 && r <= 4'(NR))
            return RCON[r];
        return '0;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        for (int unsigned i = 0; i < 16; i++)
            r[8*i +: 8] = SBOX[s[8*i +: 8]];
        return r;
    endfunction

    // Byte k sits at bits [127-8k -: 8]; row = k%4, column = k/4.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        for (int unsigned c = 0; c < 4; c++)
            for (int unsigned row = 0; row < 4; row++)
                r[127-8*(4*c+row) -: 8] = s[127-8*(4*((c+row)%4)+row) -: 8];
        return r;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        for (int unsigned c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

    function automatic logic [127:0] add_round_key(input logic [127:0] s, input logic [127:0] k);
        return s ^ k;
    endfunction

endpackage

// File: rtl/aes128_enc_ctrl_key_step.sv
// One step of the AES-128 key schedule: derives the next round key from the
// current one using RotWord, SubWord, the round constant and word chaining.
module aes128_key_step
    import hea_func_pack::*;
(
    input  logic [127:0] key_i,
    input  logic [7:0]   rcon_i,
    output logic [127:0] key_o
);

    logic [31:0] w0, w1, w2, w3, rot, temp;
    logic [31:0] n0, n1, n2, n3;

    // Expand the next four key words from the last word of the current key.
    always_comb begin
        w0   = key_i[127:96];
        w1   = key_i[95:64];
        w2   = key_i[63:32];
        w3   = key_i[31:0];
        rot  = {w3[23:0], w3[31:24]};
        temp = {SBOX[rot[31:24]], SBOX[rot[23:16]], SBOX[rot[15:8]], SBOX[rot[7:0]]}
               ^ {rcon_i, 24'h000000};
        n0   = w0 ^ temp;
        n1   = w1 ^ n0;
        n2   = w2 ^ n1;
        n3   = w3 ^ n2;
        key_o = {n0, n1, n2, n3};
    end

endmodule

// File: rtl/aes128_enc_ctrl.sv
// Iterative AES-128 encryption controller: one round per clock over a shared
// round datapath, key expanded on the fly, valid/ready on both sides.
module aes128_enc_ctrl
    import hea_func_pack::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy,
    output logic [3:0]   round_idx
);

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    aes_ctrl_state_t st_q, st_d;
    logic [127:0]    state_q, state_d;
    logic [127:0]    rkey_q, rkey_d;
    logic [3:0]      round_q, round_d;
    logic [127:0]    rk_next;
    logic [127:0]    round_core;

    aes128_key_step u_key_step (
        .key_i  (rkey_q),
        .rcon_i (get_rcon(round_q)),
        .key_o  (rk_next)
    );

    // State, working block, round key and round counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q    <= IDLE;
            state_q <= '0;
            rkey_q  <= '0;
            round_q <= '0;
        end else begin
            st_q    <= st_d;
            state_q <= state_d;
            rkey_q  <= rkey_d;
            round_q <= round_d;
        end
    end

    // Next-state logic: accept, iterate rounds, and hold the result until taken.
    always_comb begin
        st_d       = st_q;
        state_d    = state_q;
        rkey_d     = rkey_q;
        round_d    = round_q;
        in_ready   = 1'b0;
        round_core = shift_rows(sub_bytes(state_q));

        case (st_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = in_data ^ in_key;
                    rkey_d  = in_key;
                    round_d = 4'd1;
                    st_d    = ROUND;
                end
            end
            ROUND: begin
                rkey_d = rk_next;
                if (round_q == LAST_ROUND) begin
                    state_d = add_round_key(round_core, rk_next);
                    st_d    = DONE;
                end else begin
                    state_d = add_round_key(mix_columns(round_core), rk_next);
                    round_d = round_q + 4'd1;
                end
            end
            DONE: begin
                // Output handshake and a new accept can share the same edge.
                if (out_ready) begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        state_d = in_data ^ in_key;
                        rkey_d  = in_key;
                        round_d = 4'd1;
                        st_d    = ROUND;
                    end else begin
                        round_d = '0;
                        st_d    = IDLE;
                    end
                end
            end
            default: begin
                st_d = IDLE;
            end
        endcase
    end

    // Status outputs; ciphertext is only exposed while DONE.
    always_comb begin
        out_valid = (st_q == DONE);
        out_data  = (st_q == DONE) ? state_q : '0;
        busy      = (st_q != IDLE);
        round_idx = round_q;
    end

endmodule

// File: tb/tb_aes128_enc_ctrl.sv
// Self-checking bench for aes128_enc_ctrl: FIPS-197 vectors, back-pressure,
// back-to-back, mid-round reset, input hold, and random blocks against a
// byte-level AES reference model.
module tb_aes128_enc_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;
    logic [3:0]   round_idx;

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] MC_IN = 128'h63fcac161bee28c3c4c193f54b8233ea;
    localparam logic [127:0] MC_OUT = 128'h6379e6d9f467fb76ad063cf4d2eb8aa3;

    aes128_enc_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .round_idx (round_idx)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model (GF(2^8) arithmetic, full key expansion)
    logic [7:0] sb [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = '0;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d = {b, b};
        return d[15-n -: 8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            if (x != 0)
                for (int y = 1; y < 256; y++)
                    if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] ref_mix(input logic [127:0] v);
        logic [127:0] r;
        logic [7:0]   a [4];
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) a[j] = v[127-8*(4*c+j) -: 8];
            for (int j = 0; j < 4; j++)
                r[127-8*(4*c+j) -: 8] = gmul(a[j], 8'h02) ^ gmul(a[(j+1)%4], 8'h03)
                                        ^ a[(j+2)%4] ^ a[(j+3)%4];
        end
        return r;
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
        logic [31:0]  w [44];
        logic [31:0]  t;
        logic [7:0]   rc = 8'h01;
        logic [127:0] s, u;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        s = pt ^ key;
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int k = 0; k < 16; k++) s[127-8*k -: 8] = sb[s[127-8*k -: 8]];
            for (int k = 0; k < 16; k++)
                u[127-8*k -: 8] = s[127-8*((k%4) + 4*(((k/4) + (k%4)) % 4)) -: 8];
            s = (rnd < 10) ? ref_mix(u) : u;
            s = s ^ {w[4*rnd], w[4*rnd+1], w[4*rnd+2], w[4*rnd+3]};
        end
        return s;
    endfunction

    // ---------------- helpers
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for out_valid after an accept edge; checks round_idx/busy each cycle.
    task automatic wait_out(input bit garbage, output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 30) begin
            if (lat < 10) begin
                chk("round_idx", 128'(round_idx), 128'(lat + 1));
                chk("busy_round", 128'(busy), 128'(1));
                chk("in_ready_round", 128'(in_ready), 128'(0));
            end
            if (garbage) begin
                in_valid = 1'($urandom);
                in_data  = {$urandom, $urandom, $urandom, $urandom};
                in_key   = {$urandom, $urandom, $urandom, $urandom};
            end
            tick();
            lat++;
        end
        in_valid = 1'b0;
    endtask

    // One block: accept, wait, optional stall, handshake, return ciphertext.
    task automatic do_block(input string tag, input logic [127:0] pt, input logic [127:0] key,
                            input bit garbage, input int stall, output logic [127:0] ct);
        int lat;
        logic [127:0] first;
        in_valid = 1'b1;
        in_data  = pt;
        in_key   = key;
        out_ready = 1'b0;
        #1;
        chk({tag, "_in_ready"}, 128'(in_ready), 128'(1));
        tick();
        in_valid = 1'b0;
        wait_out(garbage, lat);
        chk({tag, "_latency"}, 128'(lat), 128'(10));
        first = out_data;
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            in_data  = {$urandom, $urandom, $urandom, $urandom};
            #1;
            chk({tag, "_stall_valid"}, 128'(out_valid), 128'(1));
            chk({tag, "_stall_data"}, out_data, first);
            chk({tag, "_stall_in_ready"}, 128'(in_ready), 128'(0));
            tick();
        end
        in_valid = 1'b0;
        ct = out_data;
        chk({tag, "_done_round_idx"}, 128'(round_idx), 128'(10));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_post_valid"}, 128'(out_valid), 128'(0));
        chk({tag, "_post_data"}, out_data, 128'(0));
        chk({tag, "_post_round_idx"}, 128'(round_idx), 128'(0));
        chk({tag, "_post_in_ready"}, 128'(in_ready), 128'(1));
    endtask

    // ---------------- directed sequence
    initial begin
        logic [127:0] ct, pt, key;
        int lat, found;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; in_key = '0;
        build_sbox();

        // Model sanity against published vectors, plus the package mix_columns.
        chk("model_B", aes_ref(PT_B, KEY_B), CT_B);
        chk("model_C1", aes_ref(PT_C, KEY_C), CT_C);
        chk("model_mixcol", ref_mix(MC_IN), MC_OUT);
        chk("pkg_mixcol", hea_func_pack::mix_columns(MC_IN), MC_OUT);

        tick(); tick();
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_data", out_data, 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_round_idx", 128'(round_idx), 128'(0));
        rst = 1'b0;
        tick();

        // FIPS-197 Appendix B.
        do_block("B", PT_B, KEY_B, 1'b0, 0, ct);
        chk("B_ct", ct, CT_B);

        // Appendix C.1 with garbage inputs during rounds and a 7-cycle stall.
        do_block("C1", PT_C, KEY_C, 1'b1, 7, ct);
        chk("C1_ct", ct, CT_C);

        // Back-to-back: C.1 then B with out_ready held high.
        in_valid = 1'b1; in_data = PT_C; in_key = KEY_C; out_ready = 1'b1;
        #1;
        chk("b2b_accept1", 128'(in_ready), 128'(1));
        tick();
        in_data = PT_B; in_key = KEY_B;
        found = 0;
        while (out_valid !== 1'b1 && found < 30) begin tick(); found++; end
        chk("b2b_lat1", 128'(found), 128'(10));
        chk("b2b_ct1", out_data, CT_C);
        chk("b2b_accept2", 128'(in_ready), 128'(1));
        tick();
        in_valid = 1'b0;
        chk("b2b_round1", 128'(round_idx), 128'(1));
        chk("b2b_gap_valid", 128'(out_valid), 128'(0));
        found = 1;
        while (out_valid !== 1'b1 && found < 30) begin tick(); found++; end
        chk("b2b_spacing", 128'(found), 128'(11));
        chk("b2b_ct2", out_data, CT_B);
        tick();
        out_ready = 1'b0;
        chk("b2b_idle_valid", 128'(out_valid), 128'(0));
        chk("b2b_idle_busy", 128'(busy), 128'(0));

        // Reset in the middle of round 5.
        in_valid = 1'b1; in_data = PT_C; in_key = KEY_C;
        tick();
        in_valid = 1'b0;
        found = 0;
        while (round_idx != 4'd5 && found < 20) begin tick(); found++; end
        chk("mid_reached5", 128'(round_idx), 128'(5));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_out_valid", 128'(out_valid), 128'(0));
        chk("mid_round_idx", 128'(round_idx), 128'(0));
        chk("mid_in_ready", 128'(in_ready), 128'(1));
        chk("mid_busy", 128'(busy), 128'(0));
        for (int i = 0; i < 12; i++) begin
            chk("mid_no_output", 128'(out_valid), 128'(0));
            tick();
        end
        do_block("C1_again", PT_C, KEY_C, 1'b0, 0, ct);
        chk("C1_again_ct", ct, CT_C);

        // Random blocks against the reference model.
        for (int i = 0; i < 5; i++) begin
            pt  = {$urandom, $urandom, $urandom, $urandom};
            key = {$urandom, $urandom, $urandom, $urandom};
            do_block("rnd", pt, key, 1'($urandom), int'($urandom_range(0, 3)), ct);
            chk("rnd_ct", ct, aes_ref(pt, key));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/aes128_enc_ctrl.md
# aes128_enc_ctrl

Iterative AES-128 encryption controller: one block at a time, one round per clock, reusing a single shared round datapath: sub_bytes, shift_rows, mix_columns, add_round_key. Sequences the 10 rounds, skips mix_columns on the final round, and expands the key on the fly. Sits between the HEA request interface and the combinational round functions in hea_func_pack; valid/ready handshakes on both sides.

## Interface
- Parameters: none. AES-128 only; Nr = 10 is a package constant.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  plaintext/key pair offered
- in_ready  out  1  controller can accept a pair this cycle
- in_data  in  128  plaintext; byte 0 = bits [127:120], column-major (FIPS-197 order)
- in_key  in  128  cipher key, same byte order
- out_valid  out  1  ciphertext available
- out_ready  in  1  consumer takes ciphertext
- out_data  out  128  ciphertext, held stable while out_valid=1
- busy  out  1  high in ROUND and DONE
- round_idx  out  4  current round number (0 in IDLE)

## Operation
- States: IDLE, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: state_reg <= in_data ^ in_key, rkey_reg <= in_key, round_idx <= 1, go ROUND.
- ROUND (round_idx r = 1..10), per edge:
  - rk_next = key_step(rkey_reg, rcon[r]).
  - r<10: state_reg <= add_round_key(mix_columns(shift_rows(sub_bytes(state_reg))), rk_next).
  - r=10: same round without mix_columns; go DONE.
  - rkey_reg <= rk_next; round_idx <= r+1, except it stays 10 entering DONE.
  - in_ready=0. in_valid and in_data are ignored.
- DONE:
  - out_valid=1, out_data=state_reg.
  - Hold until out_ready.
  - On out_ready: if in_valid, accept the new pair in the same cycle (load as in IDLE, go ROUND, round_idx=1); otherwise go IDLE.
- in_ready = (state==IDLE) || (state==DONE && out_ready). A combinational path from out_ready to in_ready is permitted.
- rcon sequence, r=1..10: 01,02,04,08,10,20,40,80,1b,36.
- All XOR/GF(2^8) arithmetic stays 8-bit per byte. No widening.
- Reset values: state=IDLE, in_ready=1 (combinational from IDLE), out_valid=0, out_data=0, busy=0, round_idx=0, state_reg=0, rkey_reg=0.
- Reset mid-operation (ROUND or DONE) discards the block. Next cycle matches the reset values. No partial output ever appears.
- out_data is driven from state_reg in DONE only; 0 otherwise.

## Timing
- Accept edge E0. Rounds are performed on edges E1..E10. out_valid rises in the cycle after E10.
- Latency: 10 clocks from accept edge to out_valid. 11 clocks per block at full throughput with back-to-back accept in DONE.
- Stall: out_valid and out_data stay constant for any number of cycles with out_ready=0.
- Single in/out handshake per block. No reordering.

## Structure
- hea_func_pack holds:
  - functions sub_bytes, shift_rows, mix_columns, add_round_key
  - the S-box
  - RCON array [1:10]
  - localparam NR=10
  - typedef enum aes_ctrl_state_t {IDLE, ROUND, DONE}
- One sub-module: aes128_key_step (combinational: RotWord, SubWord, rcon XOR, word chaining). Instantiated once.
- The controller holds the FSM, round counter, state_reg and rkey_reg. Target ~150-250 lines.

## Test plan
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> out_data 3925841d02dc09fbdc118597196a0b32, out_valid exactly 10 clocks after accept.
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a.
- Back-pressure: out_ready=0 for 7 cycles after out_valid -> out_data stable, in_ready=0, single beat on release.
- Back-to-back: C.1 then B presented continuously with out_ready=1 -> both results correct and in order, second accept in the same cycle as the first output handshake, 11-clock spacing.
- Reset mid-round: rst at round_idx=5 -> next cycle out_valid=0, round_idx=0, in_ready=1. A fresh C.1 run then produces the correct ciphertext.
- Input hold: in_valid toggling with garbage in_data during ROUND -> result unaffected and round_idx increments by 1 per cycle. Also check the round-1 state after mix_columns: with state input 63fcac161bee28c3c4c193f54b8233ea, the mix_columns output is 6379e6d9f467fb76ad063cf4d2eb8aa3.
